neuron_mac_sequencer: RTL and testbench

//  Sequences one neuron evaluation over the shared 128x8 neuron dual-port RAM: reads LEN input/weight pairs

---
 rtl/neuron_pkg.sv | 19 +
 rtl/neuron_clip_relu.sv | 27 ++
 rtl/neuron_mac_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_neuron_mac_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/neuron_pkg.sv
// Shared constants and state type for the neuron MAC sequencer and its clip stage.
package neuron_pkg;

    localparam int RAM_AW    = 8;
    localparam int DATA_W    = 8;
    localparam int RAM_DEPTH = 128;
    localparam int CLIP_MIN  = 0;
    localparam int CLIP_MAX  = 127;

    typedef enum logic [2:0] {
        IDLE,
        RD_IN,
        RD_W,
        RD_B,
        WRITE,
        DONE
    } state_t;

endpackage

// File: rtl/neuron_clip_relu.sv
// Post-accumulation stage: arithmetic right shift, ReLU, then saturation to 0..127.
module neuron_clip_relu
    import neuron_pkg::*;
#(
    parameter int ACC_W     = 20,
    parameter int OUT_SHIFT = 0
) (
    input  logic signed [ACC_W-1:0]  acc,
    output logic        [DATA_W-1:0] result
);

    localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'(CLIP_MAX);

    logic signed [ACC_W-1:0] shifted;

    always_comb begin
        shifted = acc >>> OUT_SHIFT;
        if (shifted[ACC_W-1]) begin
            result = DATA_W'(CLIP_MIN);
        end else if (shifted > MAX_V) begin
            result = DATA_W'(CLIP_MAX);
        end else begin
            result = shifted[DATA_W-1:0];
        end
    end

endmodule

// File: rtl/neuron_mac_sequencer.sv
// Evaluates one neuron over the shared neuron RAM: MAC of len input/weight pairs, clip, write back.
// Define NEURON_BIAS_EN to add the bias_addr port and a bias read before the result write.
module neuron_mac_sequencer
    import neuron_pkg::*;
#(
    parameter int ACC_W     = 20,
    parameter int OUT_SHIFT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [RAM_AW-1:0] in_base,
    input  logic [RAM_AW-1:0] w_base,
    input  logic [RAM_AW-1:0] out_addr,
    input  logic [7:0]        len,
`ifdef NEURON_BIAS_EN
    input  logic [RAM_AW-1:0] bias_addr,
`endif
    output logic              busy,
    output logic              done,
    output logic [RAM_AW-1:0] ram_read_address,
    output logic              ram_oe,
    input  logic [DATA_W-1:0] ram_read_data,
    output logic [RAM_AW-1:0] ram_write_address,
    output logic [DATA_W-1:0] ram_write_data,
    output logic              ram_wre
);

`ifdef NEURON_BIAS_EN
    localparam state_t MAC_EXIT = RD_B;
`else
    localparam state_t MAC_EXIT = WRITE;
`endif

    state_t state;
    state_t next_state;

    logic        [RAM_AW-1:0] in_base_r;
    logic        [RAM_AW-1:0] w_base_r;
    logic        [RAM_AW-1:0] out_addr_r;
    logic        [7:0]        len_r;
    logic        [7:0]        idx;
    logic        [DATA_W-1:0] x_reg;
    logic signed [ACC_W-1:0]  acc;
`ifdef NEURON_BIAS_EN
    logic        [RAM_AW-1:0] bias_addr_r;
`endif

    logic signed [15:0]       x_ext;
    logic signed [15:0]       d_ext;
    logic signed [15:0]       product;
    logic signed [ACC_W-1:0]  mac_term;
    logic signed [ACC_W-1:0]  bias_term;
    logic                     last_pair;
    logic        [DATA_W-1:0] clip_result;

    assign x_ext     = {{8{x_reg[7]}}, x_reg};
    assign d_ext     = {{8{ram_read_data[7]}}, ram_read_data};
    assign product   = x_ext * d_ext;
    assign mac_term  = {{(ACC_W-16){product[15]}}, product};
    assign bias_term = {{(ACC_W-DATA_W){ram_read_data[DATA_W-1]}}, ram_read_data};
    // Widened to 9 bits so idx+1 cannot wrap before being compared with len.
    assign last_pair = ({1'b0, idx} + 9'd1) >= {1'b0, len_r};

    neuron_clip_relu #(
        .ACC_W     (ACC_W),
        .OUT_SHIFT (OUT_SHIFT)
    ) u_clip (
        .acc    (acc),
        .result (clip_result)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state        = state;
        busy              = 1'b1;
        done              = 1'b0;
        ram_oe            = 1'b0;
        ram_wre           = 1'b0;
        ram_read_address  = '0;
        ram_write_address = '0;
        ram_write_data    = '0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    next_state = (len == 8'd0) ? MAC_EXIT : RD_IN;
                end
            end
            RD_IN: begin
                ram_oe           = 1'b1;
                ram_read_address = in_base_r + idx;
                next_state       = RD_W;
            end
            RD_W: begin
                ram_oe           = 1'b1;
                ram_read_address = w_base_r + idx;
                next_state       = last_pair ? MAC_EXIT : RD_IN;
            end
`ifdef NEURON_BIAS_EN
            RD_B: begin
                ram_oe           = 1'b1;
                ram_read_address = bias_addr_r;
                next_state       = WRITE;
            end
`endif
            WRITE: begin
                ram_wre           = 1'b1;
                ram_write_address = out_addr_r;
                ram_write_data    = clip_result;
                next_state        = DONE;
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: begin
                busy       = 1'b0;
                next_state = IDLE;
            end
        endcase
    end

    // Operands are captured only on an accepted start so the caller may change them mid-run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_base_r   <= '0;
            w_base_r    <= '0;
            out_addr_r  <= '0;
            len_r       <= '0;
            idx         <= '0;
            x_reg       <= '0;
            acc         <= '0;
`ifdef NEURON_BIAS_EN
            bias_addr_r <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        in_base_r   <= in_base;
                        w_base_r    <= w_base;
                        out_addr_r  <= out_addr;
                        len_r       <= len;
                        idx         <= '0;
                        acc         <= '0;
`ifdef NEURON_BIAS_EN
                        bias_addr_r <= bias_addr;
`endif
                    end
                end
                RD_IN: begin
                    x_reg <= ram_read_data;
                end
                RD_W: begin
                    acc <= acc + mac_term;
                    idx <= idx + 8'd1;
                end
`ifdef NEURON_BIAS_EN
                RD_B: begin
                    acc <= acc + bias_term;
                end
`endif
                default: begin
                end
            endcase
        end
    end

`ifndef NEURON_BIAS_EN
    logic unused_bias;
    assign unused_bias = ^bias_term;
`endif

endmodule

// File: tb/tb_neuron_mac_sequencer.sv
// Bench: two sequencers (OUT_SHIFT=1 and 0) on private RAM models, checked every cycle against a timeline model.
// Honours NEURON_BIAS_EN the same way as the design.
module tb_neuron_mac_sequencer;

    localparam int BIAS_ADDR = 8;
`ifdef NEURON_BIAS_EN
    localparam int BIAS_ON = 1;
`else
    localparam int BIAS_ON = 0;
`endif

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] in_base;
    logic [7:0] w_base;
    logic [7:0] out_addr;
    logic [7:0] len;
`ifdef NEURON_BIAS_EN
    logic [7:0] bias_addr;
`endif

    logic [1:0] busy;
    logic [1:0] done;
    logic [1:0] oe;
    logic [1:0] wre;
    logic [7:0] raddr [2];
    logic [7:0] rdata [2];
    logic [7:0] waddr [2];
    logic [7:0] wdata [2];

    logic [7:0] mem [2][128];
    logic       tb_we;
    logic [6:0] tb_wa;
    logic [7:0] tb_wd;

    int cyc = 0;
    int t0 = 0;
    bit model_active = 0;
    int m_in, m_w, m_len, m_out;
    int m_res [2];
    int wre_cnt [2];
    int done_cnt [2];
    int done_off;
    int n_cmp = 0;
    int n_err = 0;

    int cmp_c;
    int cmp_wr;
    logic [27:0] exp_vec;
    logic [27:0] act_vec;

    neuron_mac_sequencer #(.ACC_W(20), .OUT_SHIFT(1)) dut_s1 (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .in_base           (in_base),
        .w_base            (w_base),
        .out_addr          (out_addr),
        .len               (len),
`ifdef NEURON_BIAS_EN
        .bias_addr         (bias_addr),
`endif
        .busy              (busy[0]),
        .done              (done[0]),
        .ram_read_address  (raddr[0]),
        .ram_oe            (oe[0]),
        .ram_read_data     (rdata[0]),
        .ram_write_address (waddr[0]),
        .ram_write_data    (wdata[0]),
        .ram_wre           (wre[0])
    );

    neuron_mac_sequencer #(.ACC_W(20), .OUT_SHIFT(0)) dut_s0 (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .in_base           (in_base),
        .w_base            (w_base),
        .out_addr          (out_addr),
        .len               (len),
`ifdef NEURON_BIAS_EN
        .bias_addr         (bias_addr),
`endif
        .busy              (busy[1]),
        .done              (done[1]),
        .ram_read_address  (raddr[1]),
        .ram_oe            (oe[1]),
        .ram_read_data     (rdata[1]),
        .ram_write_address (waddr[1]),
        .ram_write_data    (wdata[1]),
        .ram_wre           (wre[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign rdata[0] = mem[0][raddr[0][6:0]];
    assign rdata[1] = mem[1][raddr[1][6:0]];

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (tb_we) mem[k][tb_wa] <= tb_wd;
            else if (wre[k]) mem[k][waddr[k][6:0]] <= wdata[k];
        end
    end

    function automatic int shift_of(input int k);
        return (k == 0) ? 1 : 0;
    endfunction

    // Dot product of the RAM contents as seen at start time, plus the bias word when enabled.
    function automatic int model_acc(input int k, input int ib, input int wb, input int ln);
        int s = 0;
        for (int i = 0; i < ln; i++) begin
            s += int'($signed(mem[k][(ib + i) & 127])) * int'($signed(mem[k][(wb + i) & 127]));
        end
        if (BIAS_ON != 0) s += int'($signed(mem[k][BIAS_ADDR]));
        return s;
    endfunction

    function automatic int model_clip(input int a, input int sh);
        int v = a >>> sh;
        if (v < 0) return 0;
        if (v > 127) return 127;
        return v;
    endfunction

    // Expected outputs derived from the cycle offset since the accepting edge.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            exp_vec = '0;
            cmp_c   = cyc - t0;
            cmp_wr  = 2 * m_len + BIAS_ON;
            if (model_active && !rst && cmp_c <= cmp_wr + 1) begin
                exp_vec[27] = 1'b1;
                if (cmp_c < 2 * m_len) begin
                    exp_vec[25]    = 1'b1;
                    exp_vec[23:16] = (cmp_c % 2 == 0) ? 8'(m_in + cmp_c / 2) : 8'(m_w + cmp_c / 2);
                end else if (cmp_c < cmp_wr) begin
                    exp_vec[25]    = 1'b1;
                    exp_vec[23:16] = 8'(BIAS_ADDR);
                end else if (cmp_c == cmp_wr) begin
                    exp_vec[24]    = 1'b1;
                    exp_vec[15:8]  = 8'(m_out);
                    exp_vec[7:0]   = 8'(m_res[k]);
                end else begin
                    exp_vec[26]    = 1'b1;
                end
            end
            act_vec = {busy[k], done[k], oe[k], wre[k],
                       exp_vec[25] ? raddr[k] : 8'h00,
                       exp_vec[24] ? waddr[k] : 8'h00,
                       exp_vec[24] ? wdata[k] : 8'h00};
            if (wre[k] === 1'b1) wre_cnt[k]++;
            if (done[k] === 1'b1) done_cnt[k]++;
            n_cmp++;
            if (act_vec !== exp_vec) begin
                n_err++;
                $display("[TB] FAIL cycle_outputs inst%0d cyc=%0d got=%h expected=%h", k, cyc, act_vec, exp_vec);
            end
        end
    end

    task automatic check_output(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic poke(input int a, input logic [7:0] d);
        @(negedge clk);
        tb_we = 1'b1;
        tb_wa = 7'(a);
        tb_wd = d;
        @(negedge clk);
        tb_we = 1'b0;
    endtask

    // mode 0: plain run; mode 1: extra start pulses in cycles 3 and 10; mode 2: reset during RD_W of idx 2.
    task automatic apply_stimulus(input int ib, input int wb, input int oa, input int ln, input int mode);
        int waited;
        @(negedge clk);
        in_base  = 8'(ib);
        w_base   = 8'(wb);
        out_addr = 8'(oa);
        len      = 8'(ln);
`ifdef NEURON_BIAS_EN
        bias_addr = 8'(BIAS_ADDR);
`endif
        start = 1'b1;
        for (int k = 0; k < 2; k++) begin
            m_res[k]    = model_clip(model_acc(k, ib, wb, ln), shift_of(k));
            wre_cnt[k]  = 0;
            done_cnt[k] = 0;
        end
        done_off = -1;
        @(posedge clk);
        #1;
        t0 = cyc;
        m_in = ib;
        m_w = wb;
        m_len = ln;
        m_out = oa;
        model_active = 1;
        start = 1'b0;
        in_base  = 8'h55;
        w_base   = 8'h66;
        out_addr = 8'h77;
        len      = 8'd9;
        waited = 0;
        while (done_off < 0 && waited < 600) begin
            @(negedge clk);
            start = (mode == 1 && ((cyc - t0) == 2 || (cyc - t0) == 9)) ? 1'b1 : 1'b0;
            if (mode == 2 && (cyc - t0) == 5) begin
                #2;
                rst = 1'b1;
                model_active = 0;
                #1;
                for (int k = 0; k < 2; k++) begin
                    check_output("abort_ctl_zero", {busy[k], done[k], oe[k], wre[k]}, 0);
                    check_output("abort_addr_zero", {raddr[k], waddr[k], wdata[k]}, 0);
                end
                @(posedge clk);
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            if (done[0] === 1'b1) done_off = cyc - t0 + 1;
            waited++;
        end
        if (done_off < 0) check_output("done_timeout", 0, 1);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        in_base = '0;
        w_base = '0;
        out_addr = '0;
        len = '0;
`ifdef NEURON_BIAS_EN
        bias_addr = '0;
`endif
        tb_we = 1'b0;
        tb_wa = '0;
        tb_wd = '0;

        poke(0, 8'd10); poke(1, 8'd11); poke(2, 8'd10); poke(3, 8'd11);
        poke(4, 8'd4);  poke(5, 8'd5);  poke(6, 8'd3);  poke(7, 8'd2);
        poke(8, 8'hFB); poke(20, 8'd0); poke(21, 8'd0); poke(22, 8'd0);

        check_output("reset_ctl", {busy, done, oe, wre}, 0);
        check_output("reset_out_s1", {raddr[0], waddr[0], wdata[0]}, 0);
        check_output("reset_out_s0", {raddr[1], waddr[1], wdata[1]}, 0);
        @(negedge clk);
        rst = 1'b0;

        check_output("model_t1_acc", model_acc(0, 0, 4, 4), BIAS_ON ? 142 : 147);
        apply_stimulus(0, 4, 20, 4, 0);
        check_output("t1_mem20_shift1", mem[0][20], BIAS_ON ? 71 : 73);
        check_output("t2_mem20_shift0_sat", mem[1][20], 127);
        check_output("t1_done_latency", done_off, BIAS_ON ? 11 : 10);
        check_output("t2_single_wre", wre_cnt[1], 1);

        poke(20, 8'hAA);
        apply_stimulus(0, 4, 20, 4, 1);
        check_output("t5_writes_s1", wre_cnt[0], 1);
        check_output("t5_writes_s0", wre_cnt[1], 1);
        check_output("t5_dones_s1", done_cnt[0], 1);
        check_output("t5_mem20_shift1", mem[0][20], BIAS_ON ? 71 : 73);

        poke(22, 8'hAA);
        check_output("model_pair_acc", model_acc(0, 2, 6, 2), BIAS_ON ? 47 : 52);
        apply_stimulus(2, 6, 22, 2, 0);
        check_output("pair_mem22_shift1", mem[0][22], BIAS_ON ? 23 : 26);
        check_output("pair_mem22_shift0", mem[1][22], BIAS_ON ? 47 : 52);

        poke(21, 8'hAA);
        apply_stimulus(0, 4, 21, 0, 0);
        check_output("t4_mem21_shift1", mem[0][21], 0);
        check_output("t4_mem21_shift0", mem[1][21], 0);
        check_output("t4_done_latency", done_off, BIAS_ON ? 3 : 2);

        poke(4, 8'hF0);
        poke(20, 8'hAA);
        check_output("model_t3_acc", model_acc(1, 0, 4, 4), BIAS_ON ? -58 : -53);
        apply_stimulus(0, 4, 20, 4, 0);
        check_output("t3_mem20_relu_s1", mem[0][20], 0);
        check_output("t3_mem20_relu_s0", mem[1][20], 0);

        poke(4, 8'd4);
        poke(20, 8'hAA);
        apply_stimulus(0, 4, 20, 4, 2);
        check_output("t6_no_write_s1", mem[0][20], 8'hAA);
        check_output("t6_no_write_s0", mem[1][20], 8'hAA);
        check_output("t6_no_done", done_cnt[0] + done_cnt[1], 0);
        apply_stimulus(0, 4, 20, 4, 0);
        check_output("t6_rerun_shift1", mem[0][20], BIAS_ON ? 71 : 73);
        check_output("t6_rerun_shift0", mem[1][20], 127);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
